// File: rtl/float_pair_sequencer_pkg.sv
// Shared types and constants for the float edge-case pair sequencer.
// Holds the FSM encoding, the operand table values and a saturating 8-bit increment.
package float_pair_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  localparam int NUM_VALS_DEFAULT = 6;

  localparam logic [31:0] FP_VERY_LARGE = 32'h7E4CCCCC;
  localparam logic [31:0] FP_VERY_SMALL = 32'h01866666;
  localparam logic [31:0] FP_NEG_TENTH  = 32'hBDCCCCCC;
  localparam logic [31:0] FP_NEG_FIFTH  = 32'hBE4CCCCC;
  localparam logic [31:0] FP_ZERO       = 32'h00000000;
  localparam logic [31:0] FP_POS_INF    = 32'h7F800000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/float_pair_sequencer_rom.sv
// Combinational edge-case operand table; zero for indices past the table.
// No latency, no flow control.
module float_edgecase_rom
  import float_pair_sequencer_pkg::*;
(
  input  logic [2:0]  idx,
  output logic [31:0] value
);

  always_comb begin
    value = FP_ZERO;
    case (idx)
      3'd0:    value = FP_VERY_LARGE;
      3'd1:    value = FP_VERY_SMALL;
      3'd2:    value = FP_NEG_TENTH;
      3'd3:    value = FP_NEG_FIFTH;
      3'd4:    value = FP_ZERO;
      3'd5:    value = FP_POS_INF;
      default: value = FP_ZERO;
    endcase
  end

endmodule

// File: rtl/float_pair_sequencer.sv
// Walks every ordered operand pair through a unit under test, counting results/timeouts and folding results into a signature.
// Operands held until op_ready; each result awaited for at most TIMEOUT cycles; abort and reset end a run without done.
module float_pair_sequencer
  import float_pair_sequencer_pkg::*;
#(
  parameter int NUM_VALS = NUM_VALS_DEFAULT,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic [31:0] res,
  input  logic        res_valid,
  output logic [7:0]  result_count,
  output logic [7:0]  timeout_count,
  output logic [31:0] signature
);

  localparam logic [2:0] LAST_IDX   = 3'(NUM_VALS - 1);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  seq_state_t  r_state;
  logic [2:0]  r_i;
  logic [2:0]  r_j;
  logic [7:0]  r_timer;
  logic [7:0]  r_result_count;
  logic [7:0]  r_timeout_count;
  logic [31:0] r_signature;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_busy;
  logic        r_done;
  logic        r_op_valid;

  logic        w_j_wrap;
  logic        w_last;
  logic [2:0]  w_i_nxt;
  logic [2:0]  w_j_nxt;
  logic [2:0]  w_rom_a_idx;
  logic [2:0]  w_rom_b_idx;
  logic [31:0] w_rom_a;
  logic [31:0] w_rom_b;

  assign w_j_wrap = (r_j == LAST_IDX);
  assign w_last   = w_j_wrap && (r_i == LAST_IDX);
  assign w_j_nxt  = w_j_wrap ? 3'd0 : r_j + 3'd1;
  assign w_i_nxt  = w_j_wrap ? r_i + 3'd1 : r_i;

  // ROMs look up the pair about to be issued so the operands register on ISSUE entry.
  assign w_rom_a_idx = (r_state == S_IDLE) ? 3'd0 : w_i_nxt;
  assign w_rom_b_idx = (r_state == S_IDLE) ? 3'd0 : w_j_nxt;

  float_edgecase_rom u_rom_a (.idx(w_rom_a_idx), .value(w_rom_a));
  float_edgecase_rom u_rom_b (.idx(w_rom_b_idx), .value(w_rom_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_i             <= 3'd0;
      r_j             <= 3'd0;
      r_timer         <= 8'd0;
      r_result_count  <= 8'd0;
      r_timeout_count <= 8'd0;
      r_signature     <= 32'd0;
      r_op_a          <= 32'd0;
      r_op_b          <= 32'd0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_op_valid      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_op_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_i             <= 3'd0;
              r_j             <= 3'd0;
              r_timer         <= 8'd0;
              r_result_count  <= 8'd0;
              r_timeout_count <= 8'd0;
              r_signature     <= 32'd0;
              r_op_a          <= w_rom_a;
              r_op_b          <= w_rom_b;
              r_op_valid      <= 1'b1;
              r_busy          <= 1'b1;
              r_state         <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (op_ready) begin
              r_op_valid <= 1'b0;
              r_timer    <= 8'd0;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (res_valid) begin
              r_result_count <= sat_inc8(r_result_count);
              r_signature    <= {r_signature[30:0], r_signature[31]} ^ res;
              r_state        <= S_NEXT;
            end else if (r_timer == TIMER_LAST) begin
              r_timeout_count <= sat_inc8(r_timeout_count);
              r_state         <= S_NEXT;
            end else begin
              r_timer <= r_timer + 8'd1;
            end
          end
          S_NEXT: begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_i        <= w_i_nxt;
              r_j        <= w_j_nxt;
              r_op_a     <= w_rom_a;
              r_op_b     <= w_rom_b;
              r_op_valid <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy     <= 1'b0;
            r_op_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign op_a          = r_op_a;
  assign op_b          = r_op_b;
  assign op_valid      = r_op_valid;
  assign result_count  = r_result_count;
  assign timeout_count = r_timeout_count;
  assign signature     = r_signature;

endmodule

// File: tb/tb_float_pair_sequencer.sv
// Bench for float_pair_sequencer: negedge responder/checker against a pair-order model, plus directed run scenarios.
`timescale 1ns/1ps
module tb_float_pair_sequencer;

  localparam int NV     = 6;
  localparam int NPAIRS = NV * NV;

  logic [31:0] tbl [NV] = '{32'h7E4CCCCC, 32'h01866666, 32'hBDCCCCCC,
                            32'hBE4CCCCC, 32'h00000000, 32'h7F800000};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        op_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res = 32'd0;
  logic        busy, done, op_valid;
  logic [31:0] op_a, op_b, signature;
  logic [7:0]  result_count, timeout_count;

  int n_chk = 0;
  int n_bad = 0;
  int mode = 0;
  bit stray_en = 1'b0;
  int exp_k = 0;
  int run_hs = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  bit pend = 1'b0;
  logic [31:0] pend_res = 32'd0;

  float_pair_sequencer #(.NUM_VALS(NV), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .op_ready(op_ready), .res(res), .res_valid(res_valid),
    .result_count(result_count), .timeout_count(timeout_count), .signature(signature)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Signature after the first n results when every result is op_a ^ op_b.
  function automatic logic [31:0] model_sig(input int n);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < n; k++)
      s = {s[30:0], s[31]} ^ (tbl[k / NV] ^ tbl[k % NV]);
    return s;
  endfunction

  // Responder and per-cycle checker, all at the falling edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_k = 0; run_hs = 0; pend = 1'b0;
        op_ready = 1'b1; res_valid = 1'b0; res = 32'd0;
      end else begin
        res_valid = 1'b0;
        res = 32'd0;
        if (pend && mode != 1) begin
          res_valid = 1'b1; res = pend_res;
        end else if (stray_en && (op_valid || !busy)) begin
          res_valid = 1'b1; res = 32'hDEADBEEF;
        end
        pend = 1'b0;
        if (!busy) begin
          exp_k = 0; run_hs = 0;
        end
        if (op_valid && exp_k == 0) stall_cnt = 0;
        op_ready = 1'b1;
        if (mode == 2 && op_valid && exp_k == 15 && stall_cnt < 5) begin
          op_ready = 1'b0; stall_cnt++;
        end
        if (op_valid) begin
          chk("busy_with_valid", busy, 32'd1);
          if (exp_k < NPAIRS) begin
            chk("op_a", op_a, tbl[exp_k / NV]);
            chk("op_b", op_b, tbl[exp_k % NV]);
          end else begin
            chk("extra_issue", exp_k, NPAIRS - 1);
          end
          if (exp_k == 0) chk("pin_op_a_00", op_a, 32'h7E4CCCCC);
          if (exp_k == 15) begin
            chk("pin_op_a_23", op_a, 32'hBDCCCCCC);
            chk("pin_op_b_23", op_b, 32'hBE4CCCCC);
          end
          if (op_ready) begin
            pend = 1'b1; pend_res = op_a ^ op_b;
            exp_k++; run_hs++;
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int limit, input bit poke, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < limit) begin
      tick();
      cyc++;
      if (done) seen = 1'b1;
      else start = poke && (cyc % 17 == 5);
    end
    start = 1'b0;
    n_chk++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_wait: no done within %0d cycles, got busy=%0d expected done=1", limit, busy);
    end
  endtask

  task automatic run_check(input string tag, input int erc, input int etc_,
                           input logic [31:0] esig, input bit poke, output int cyc);
    int d0;
    int c;
    d0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_clr_rc"}, result_count, 32'd0);
    chk({tag, "_clr_tc"}, timeout_count, 32'd0);
    chk({tag, "_clr_sig"}, signature, 32'd0);
    wait_done(3000, poke, c);
    cyc = c + 1;
    chk({tag, "_rc"}, result_count, erc);
    chk({tag, "_tc"}, timeout_count, etc_);
    chk({tag, "_sig"}, signature, esig);
    chk({tag, "_handshakes"}, run_hs, NPAIRS);
    chk({tag, "_busy_in_done"}, busy, 32'd1);
    tick();
    chk({tag, "_done_once"}, done_cnt - d0, 32'd1);
    chk({tag, "_done_low"}, done, 32'd0);
    chk({tag, "_idle"}, busy, 32'd0);
    chk({tag, "_rc_held"}, result_count, erc);
    chk({tag, "_sig_held"}, signature, esig);
  endtask

  task automatic abort_in_wait(input int k);
    int n;
    int d0;
    n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (exp_k <= k && n < 2000) begin
      tick();
      n++;
    end
    chk("abort_reach_pair", (exp_k > k), 32'd1);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 32'd0);
    chk("abort_op_valid", op_valid, 32'd0);
    chk("abort_rc", result_count, k);
    chk("abort_tc", timeout_count, 32'd0);
    chk("abort_sig", signature, model_sig(k));
    tick();
    tick();
    chk("abort_no_done", done_cnt - d0, 32'd0);
    chk("abort_rc_held", result_count, k);
  endtask

  initial begin : scenario
    int cyc;
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_op_valid", op_valid, 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_rc", result_count, 32'd0);
    chk("rst_tc", timeout_count, 32'd0);
    chk("rst_sig", signature, 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    mode = 0;
    run_check("norm", NPAIRS, 0, model_sig(NPAIRS), 1'b0, cyc);

    mode = 1;
    run_check("tmo", 0, NPAIRS, 32'd0, 1'b0, cyc);
    chk("tmo_cycles", cyc, 32'd649);

    mode = 2;
    run_check("stall", NPAIRS, 0, model_sig(NPAIRS), 1'b0, cyc);
    chk("stall_len", stall_cnt, 32'd5);

    mode = 0;
    abort_in_wait(2);
    chk("pin_sig_2", signature, 32'h7FCAAAAA);
    abort_in_wait(10);
    run_check("rerun", NPAIRS, 0, model_sig(NPAIRS), 1'b0, cyc);

    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(op_valid && exp_k == 3) && n < 500) begin
      tick();
      n++;
    end
    chk("mid_issue_reached", op_valid, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 32'd0);
    chk("arst_op_valid", op_valid, 32'd0);
    chk("arst_op_a", op_a, 32'd0);
    chk("arst_op_b", op_b, 32'd0);
    chk("arst_rc", result_count, 32'd0);
    chk("arst_sig", signature, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_check("post_rst", NPAIRS, 0, model_sig(NPAIRS), 1'b0, cyc);

    stray_en = 1'b1;
    repeat (4) tick();
    run_check("stray", NPAIRS, 0, model_sig(NPAIRS), 1'b1, cyc);
    repeat (3) tick();
    chk("stray_idle_busy", busy, 32'd0);
    chk("stray_idle_rc", result_count, NPAIRS);
    stray_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
    $fatal(1, "watchdog expired");
  end

endmodule
